// File: rtl/fetch_stage.sv
// Instruction fetch stage: a pointer issues reads, returning words pass through an output register with a one-entry skid buffer.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and raises misaligned.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  pc_src,
    input  logic [ADDR_WIDTH-1:0] imm_op,
    output logic                  misaligned
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  misaligned_q, misaligned_d;

    logic                  issue_c;
    logic                  xfer_c;
    logic                  arrive_c;
    logic                  redirect_c;
    logic                  target_bad_c;
    logic [ADDR_WIDTH-1:0] target_c;

    // Next-state: fetch issue, word placement, redirect and halt.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        infl_d       = 1'b0;
        infl_pc_d    = infl_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        misaligned_d = misaligned_q;

        issue_c    = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && !skid_valid_q;
        xfer_c     = out_valid_q && instr_ready;
        arrive_c   = infl_q && (state_q == ST_RUN);
        redirect_c = xfer_c && pc_src;
`ifdef FETCH_MISALIGN_TRAP_EN
        target_c     = out_pc_q + imm_op;
        target_bad_c = |target_c[1:0];
`else
        target_c     = (out_pc_q + imm_op) & ~ADDR_WIDTH'(3);
        target_bad_c = 1'b0;
`endif

        if (issue_c) begin
            fpc_d     = fpc_q + ADDR_WIDTH'(4);
            infl_d    = 1'b1;
            infl_pc_d = fpc_q;
        end
        if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
        end

        if (redirect_c) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            infl_d       = 1'b0;
            if (target_bad_c) begin
                state_d      = ST_HALT;
                misaligned_d = 1'b1;
            end else begin
                state_d = ST_FLUSH;
                fpc_d   = target_c;
            end
        end else if (xfer_c) begin
            if (skid_valid_q) begin
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = arrive_c;
                skid_instr_d = arrive_c ? imem_rdata : skid_instr_q;
                skid_pc_d    = arrive_c ? infl_pc_q : skid_pc_q;
            end else if (arrive_c) begin
                out_instr_d = imem_rdata;
                out_pc_d    = infl_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (arrive_c) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata;
                out_pc_d    = infl_pc_q;
            end else if (!skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = infl_pc_q;
            end else begin
                // No room for this word: rewind so it is refetched once the skid drains.
                fpc_d = infl_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            fpc_q        <= RESET_VECTOR;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_addr   = fpc_q;
    assign instr       = out_instr_q;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_valid_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random ready/redirect traffic against a pc-sequence model.
module tb_fetch_stage;

    localparam int unsigned     AW   = 32;
    localparam int unsigned     DW   = 32;
    localparam logic [AW-1:0]   RV   = 32'h0;
    localparam logic [DW-1:0]   DKEY = 32'hC0DE_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          pc_src;
    logic [AW-1:0] imm_op;
    logic          misaligned;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] m_last;
    bit            m_halt;

    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_instr;
    logic [AW-1:0] prev_pc;
    logic [AW-1:0] sb_e;

    bit            r_rdy, r_src;
    logic [AW-1:0] r_imm;

    fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VECTOR(RV)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_src     (pc_src),
        .imm_op     (imm_op),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    // Memory word differs from its address so pc/data swaps are visible.
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return DW'(a) ^ DKEY;
    endfunction

    always @(posedge clk) imem_rdata <= word_of(imem_addr);

    function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc, input bit taken,
                                              input logic [AW-1:0] imm);
        logic [AW-1:0] t;
        if (!taken) return pc + 32'd4;
        t = pc + imm;
`ifndef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive this cycle's inputs; a transfer advances the model and queues the next expected pc.
    task automatic drive_now(input bit rdy, input bit src, input logic [AW-1:0] imm);
        logic [AW-1:0] t;
        instr_ready = rdy;
        pc_src      = src;
        imm_op      = imm;
        if (instr_valid && rdy && !m_halt) begin
            t = m_last + imm;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (src && (t[1:0] != 2'b00)) m_halt = 1'b1;
`endif
            if (!m_halt) begin
                m_last = next_pc(m_last, src, imm);
                exp_q.push_back(m_last);
            end
        end
    endtask

    task automatic step(input bit rdy, input bit src, input logic [AW-1:0] imm);
        @(posedge clk); #1;
        drive_now(rdy, src, imm);
    endtask

    task automatic reset_body();
        rst         = 1'b1;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        imm_op      = '0;
        exp_q.delete();
        m_last = RV;
        m_halt = 1'b0;
        exp_q.push_back(RV);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_body();
    endtask

    task automatic wait_pc(input logic [AW-1:0] pc);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (instr_valid && (m_last == pc)) return;
            drive_now(1'b1, 1'b0, '0);
        end
        total++;
        bad++;
        $display("FAIL wait_pc: pc 0x%0h not presented within 64 cycles", pc);
    endtask

    // Reset values, then the fetch address and first-valid timing after reset release.
    task automatic check_startup();
        @(negedge clk);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                step(1'b1, 1'b0, '0);
                @(negedge clk);
            end
            chk("start_addr", imem_addr, RV + 32'(4 * k));
            chk("start_valid", 32'(instr_valid), 32'(k >= 2));
            if (k >= 2) chk("start_pc", instr_pc, RV + 32'(4 * (k - 2)));
        end
    endtask

    // Scoreboard monitor plus hold-stability check.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(instr_valid), 32'h1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", instr_pc, prev_pc);
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc 0x%0h want no transfer", instr_pc);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, sb_e);
                    chk("sb_instr", instr, word_of(sb_e));
                end
            end
            hold_prev  = instr_valid && !instr_ready;
            prev_instr = instr;
            prev_pc    = instr_pc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        imm_op      = '0;
        m_last      = RV;
        m_halt      = 1'b0;

        do_reset();
        check_startup();

        // Decode stalls four cycles while pc 8 is presented.
        do_reset();
        wait_pc(32'h8);
        drive_now(1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(1'b0, 1'b0, '0);
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, word_of(32'h8));
        end
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("release_pc", instr_pc, 32'h8);
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("after_release_pc", instr_pc, 32'hC);

        // pc_src without a transfer must be ignored.
        wait_pc(32'h10);
        drive_now(1'b0, 1'b1, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("nored_pc", instr_pc, 32'h10);
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("nored_next_pc", instr_pc, 32'h14);

        // Taken branch -8 from 0x20.
        wait_pc(32'h20);
        drive_now(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, '0);
            @(negedge clk);
            chk("redir_valid", 32'(instr_valid), 32'(k == 3));
            if (k == 3) chk("redir_pc", instr_pc, 32'h18);
        end

        // Redirect from 0x30 to the misaligned target 0x1A.
        wait_pc(32'h30);
        drive_now(1'b1, 1'b1, 32'hFFFF_FFEA);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, '0);
            @(negedge clk);
            chk("trap_valid", 32'(instr_valid), 32'h0);
            chk("trap_misaligned", 32'(misaligned), 32'h1);
        end
`else
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, '0);
            @(negedge clk);
            chk("misal_valid", 32'(instr_valid), 32'(k == 3));
            chk("misal_flag", 32'(misaligned), 32'h0);
            if (k == 3) chk("misal_pc", instr_pc, 32'h18);
        end
`endif

        // Reset while the skid is full and a fetch is in flight.
        do_reset();
        wait_pc(32'h8);
        drive_now(1'b0, 1'b0, '0);
        do_reset();
        check_startup();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 599) == 0) begin
                reset_body();
            end else begin
                r_rdy = ($urandom_range(0, 9) < 7);
                r_src = ($urandom_range(0, 7) == 0);
                r_imm = 32'($urandom_range(0, 511)) - 32'd256;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_imm[1:0] = 2'b00;
`endif
                drive_now(r_rdy, r_src, r_imm);
            end
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("final_misaligned", 32'(misaligned), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, instruction address width.
REQ-002 Parameter: DATA_WIDTH, 32, instruction word width.
REQ-003 Parameter: RESET_VECTOR, 0, first fetch address after reset.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous and active-high.
REQ-006 Port: imem_addr  out  ADDR_WIDTH  instruction memory read address.
REQ-007 Port: imem_rdata  in  DATA_WIDTH  memory word, valid the cycle after the address is issued.
REQ-008 Port: instr  out  DATA_WIDTH  instruction presented to decode.
REQ-009 Port: instr_pc  out  ADDR_WIDTH  address of instr.
REQ-010 Port: instr_valid  out  1  instr/instr_pc valid.
REQ-011 Port: instr_ready  in  1  decode accepts; transfer = instr_valid && instr_ready.
REQ-012 Port: pc_src  in  1  take branch for the instruction being transferred.
REQ-013 Port: imm_op  in  ADDR_WIDTH  signed branch offset, sampled with pc_src.
REQ-014 Port: misaligned  out  1  sticky misaligned-target flag.

Function
REQ-015 Internal fetch pointer fpc drives imem_addr; fetch issued in a cycle when state is RUN or FLUSH and the skid buffer is empty; fpc += 4 per issue, wrapping modulo 2^ADDR_WIDTH.
REQ-016 In-flight tag records pc of the issued fetch; returning word enters output register if it is empty or transferring this cycle, else enters the one-entry skid buffer.
REQ-017 On transfer with skid full, skid contents move to output register that edge.
REQ-018 While instr_valid && !instr_ready, instr and instr_pc SHALL hold stable.
REQ-019 Issue-to-instr_valid latency 2 cycles; sustained throughput 1 instr/cycle with instr_ready held high.
REQ-020 States: RUN (normal), FLUSH (discard arriving word, issue fetch at fpc, next RUN), HALT (no issue, instr_valid 0, exit only by rst).
REQ-021 pc_src honoured only on a transfer; target = instr_pc + imm_op (modulo 2^ADDR_WIDTH); pc_src ignored otherwise.
REQ-022 On honoured redirect: fpc <= target, output register and skid cleared, state <= FLUSH; instr_valid low next cycle; target instruction valid 3 cycles after the redirect edge.
REQ-023 Redirect with skid full or fetch in flight: all buffered/in-flight words discarded, none reach instr.
REQ-024 Back-to-back redirects: each honoured redirect restarts FLUSH from its own target.

Reset
REQ-025 rst overrides all other inputs in the same cycle.
REQ-026 Reset values: fpc = RESET_VECTOR, state RUN, instr_valid 0, instr 0, instr_pc 0, skid empty, no fetch in flight, misaligned 0.
REQ-027 rst mid-operation discards any in-flight word; first post-reset fetch at RESET_VECTOR in the cycle after rst falls.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect target with [1:0] != 0 sets misaligned, state <= HALT, no fetch issued.
REQ-029 Macro undefined: target[1:0] forced to 00, redirect proceeds normally, misaligned tied 0.

Verification
REQ-030 Reset release, instr_ready=1, memory word=addr -> imem_addr 0,4,8...; instr_valid first high cycle 2 with instr_pc 0, then one per cycle.
REQ-031 instr_ready low 4 cycles at instr_pc 8 -> instr/instr_pc stable at 8, no word lost or duplicated, fetches stop with skid full, 12 follows 8 on release.
REQ-032 pc_src=1, imm_op=-8 on transfer of instr_pc 0x20 -> instr_valid low, next valid instr_pc 0x18 exactly 3 cycles later, 0x24/0x28 never presented.
REQ-033 pc_src=1 while instr_ready=0 -> no redirect, sequence continues.
REQ-034 Redirect target 0x1A: with FETCH_MISALIGN_TRAP_EN misaligned=1, instr_valid stays 0 until rst; without, next instr_pc 0x18.
REQ-035 rst pulsed while skid full and fetch in flight -> all state cleared, next fetch at RESET_VECTOR, no stale word presented.
